// File: rtl/piso_shift_register_if.sv
// Parallel-load / serial-out bus between a word producer and the PISO register.
interface piso_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] data;
  logic             value;
  logic             valid;
  logic             last;
  logic [CW-1:0]    busy_count;

  modport master (
    output load, data,
    input  value, valid, last, busy_count
  );

  modport slave (
    input  load, data,
    output value, valid, last, busy_count
  );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register with valid/last framing and a remaining-bit count.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_shift_register_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (bus.load) begin
      sreg_d = bus.data;
      cnt_d  = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      // Zeros are shifted in so value drops to 0 once the word is exhausted.
      if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.value      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign bus.valid      = (cnt_q != '0);
  assign bus.last       = (cnt_q == CW'(1));
  assign bus.busy_count = cnt_q;
endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: MSB-first vector table plus LSB-first and reset sequences.
module tb_piso_shift_register;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  piso_shift_register_if #(.WIDTH(8)) bus_m ();
  piso_shift_register_if #(.WIDTH(8)) bus_l ();

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  typedef struct {
    logic       load;
    logic [7:0] data;
    logic       exp_value;
    logic       exp_valid;
    logic       exp_last;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [7:0] d, input logic v,
                     input logic vl, input logic l, input logic [3:0] c);
    vec_t t;
    t.load = ld; t.data = d; t.exp_value = v; t.exp_valid = vl; t.exp_last = l; t.exp_cnt = c;
    vecs.push_back(t);
  endtask

  task automatic check_m(input string tag, input logic v, input logic vl,
                         input logic l, input logic [3:0] c);
    check({tag, ".value"}, 32'(bus_m.value), 32'(v));
    check({tag, ".valid"}, 32'(bus_m.valid), 32'(vl));
    check({tag, ".last"},  32'(bus_m.last),  32'(l));
    check({tag, ".cnt"},   32'(bus_m.busy_count), 32'(c));
  endtask

  task automatic check_l(input string tag, input logic v, input logic vl,
                         input logic l, input logic [3:0] c);
    check({tag, ".value"}, 32'(bus_l.value), 32'(v));
    check({tag, ".valid"}, 32'(bus_l.valid), 32'(vl));
    check({tag, ".last"},  32'(bus_l.last),  32'(l));
    check({tag, ".cnt"},   32'(bus_l.busy_count), 32'(c));
  endtask

  // Bits following the first one, in shift order, for each pattern.
  logic [6:0] tail_p1 = 7'b1101001;  // 8'b01101001 MSB first, first bit 0
  logic [6:0] tail_p2 = 7'b0010110;  // 8'b10010110 MSB first, first bit 1
  logic [7:0] lsb_p   = 8'b10010110; // 8'b01101001 LSB first, in shift order

  initial begin
    bus_m.load = 1'b0; bus_m.data = '0;
    bus_l.load = 1'b0; bus_l.data = '0;

    // Pattern 1: two load cycles then 18 shift/idle cycles.
    add(1, 8'b01101001, 0, 1, 0, 8);
    add(1, 8'b01101001, 0, 1, 0, 8);
    for (int unsigned k = 0; k < 7; k++)
      add(0, 8'h00, tail_p1[6-k], 1, (k == 6), 4'(7 - k));
    for (int unsigned k = 0; k < 11; k++) add(0, 8'h00, 0, 0, 0, 0);

    // Pattern 2.
    add(1, 8'b10010110, 1, 1, 0, 8);
    add(1, 8'b10010110, 1, 1, 0, 8);
    for (int unsigned k = 0; k < 7; k++)
      add(0, 8'h00, tail_p2[6-k], 1, (k == 6), 4'(7 - k));
    for (int unsigned k = 0; k < 11; k++) add(0, 8'h00, 0, 0, 0, 0);

    // Reload mid-shift: FF, 3 shifts, then 00 replaces it.
    add(1, 8'hFF, 1, 1, 0, 8);
    add(0, 8'h00, 1, 1, 0, 7);
    add(0, 8'h00, 1, 1, 0, 6);
    add(0, 8'h00, 1, 1, 0, 5);
    add(1, 8'h00, 0, 1, 0, 8);
    for (int unsigned k = 0; k < 7; k++) add(0, 8'h00, 0, 1, (k == 6), 4'(7 - k));
    add(0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0);

    // Idle stability after reset.
    repeat (2) @(posedge clk);
    #1;
    check_m("rst_hold", 0, 0, 0, 0);
    check_l("rst_hold_lsb", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check_m("idle", 0, 0, 0, 0);
      check("idle.noX", 32'($isunknown({bus_m.value, bus_m.valid, bus_m.last, bus_m.busy_count})), 0);
    end

    // Table-driven MSB-first vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      bus_m.load = vecs[i].load;
      bus_m.data = vecs[i].data;
      @(posedge clk); #1;
      check_m($sformatf("vec%0d", i), vecs[i].exp_value, vecs[i].exp_valid,
              vecs[i].exp_last, vecs[i].exp_cnt);
    end
    @(negedge clk);
    bus_m.load = 1'b0;

    // LSB-first: single set bit appears first.
    bus_l.load = 1'b1; bus_l.data = 8'b00000001;
    @(posedge clk); #1;
    check_l("lsb1.load", 1, 1, 0, 8);
    @(negedge clk); bus_l.load = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check_l("lsb1.shift", 0, 1, (k == 6), 4'(7 - k));
    end
    @(posedge clk); #1;
    check_l("lsb1.done", 0, 0, 0, 0);

    // LSB-first with a mixed pattern.
    @(negedge clk); bus_l.load = 1'b1; bus_l.data = 8'b01101001;
    @(posedge clk); #1;
    check_l("lsb2.load", lsb_p[7], 1, 0, 8);
    @(negedge clk); bus_l.load = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check_l("lsb2.shift", lsb_p[6-k], 1, (k == 6), 4'(7 - k));
    end
    @(posedge clk); #1;
    check_l("lsb2.done", 0, 0, 0, 0);

    // Asynchronous reset mid-shift, between clock edges.
    @(negedge clk); bus_m.load = 1'b1; bus_m.data = 8'hA5;
    @(posedge clk); #1;
    check_m("prerst.load", 1, 1, 0, 8);
    @(negedge clk); bus_m.load = 1'b0;
    @(posedge clk); #1;
    check_m("prerst.shift", 0, 1, 0, 7);
    #2 rst = 1'b1;
    #1;
    check_m("async_rst", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_m("post_rst", 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
